// File: rtl/matriz_tablero.sv
// ROWS x COLS board of WIDTH-bit cells with single-cell writes, registered reads and a row-per-cycle clear.
// Define MATRIZ_TABLERO_OCC_EN to build the non-zero cell counter; otherwise occ_count is tied to 0.
module matriz_tablero #(
  parameter int ROWS  = 8,
  parameter int COLS  = 8,
  parameter int WIDTH = 9
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 clr_req,
  input  logic                                 wr_en,
  input  logic [4:0]                           wr_row,
  input  logic [4:0]                           wr_col,
  input  logic [WIDTH-1:0]                     wr_data,
  output logic                                 wr_ack,
  output logic                                 wr_err,
  input  logic [4:0]                           rd_row,
  input  logic [4:0]                           rd_col,
  output logic [WIDTH-1:0]                     rd_data,
  output logic                                 busy,
  output logic                                 clr_done,
  output logic [$clog2(ROWS*COLS+1)-1:0]       occ_count,
  output logic [ROWS*COLS*WIDTH-1:0]           matrix_flat
);

  localparam int         OCC_W    = $clog2(ROWS*COLS+1);
  localparam logic [5:0] ROWS_L   = 6'(ROWS);
  localparam logic [5:0] COLS_L   = 6'(COLS);
  localparam logic [4:0] ROW_LAST = 5'(ROWS-1);

  typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_e;

  state_e           state_q, state_d;
  logic [4:0]       row_q, row_d;
  logic [WIDTH-1:0] cells_q [ROWS][COLS];
  logic [WIDTH-1:0] cells_d [ROWS][COLS];
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             wr_ack_q, wr_ack_d;
  logic             wr_err_q, wr_err_d;
  logic             wr_accept, wr_in_range;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    case (state_q)
      IDLE:  if (clr_req) begin
               state_d = CLEAR;
               row_d   = '0;
             end
      CLEAR: if (row_q == ROW_LAST) state_d = DONE;
             else                   row_d   = row_q + 5'd1;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state_q != IDLE);
    clr_done = (state_q == DONE);
  end

  // A clear request wins over a same-cycle write; writes are only taken in IDLE.
  always_comb begin
    wr_in_range = ({1'b0, wr_row} < ROWS_L) && ({1'b0, wr_col} < COLS_L);
    wr_accept   = wr_en && (state_q == IDLE) && !clr_req;
    wr_ack_d    = wr_accept && wr_in_range;
    wr_err_d    = wr_accept && !wr_in_range;
    rd_data_d   = '0;
    cells_d     = cells_q;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (state_q == CLEAR && row_q == 5'(r)) cells_d[r][c] = '0;
        if (wr_ack_d && wr_row == 5'(r) && wr_col == 5'(c)) cells_d[r][c] = wr_data;
        if (rd_row == 5'(r) && rd_col == 5'(c)) rd_data_d = cells_q[r][c];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          cells_q[r][c] <= '0;
      rd_data_q <= '0;
      wr_ack_q  <= 1'b0;
      wr_err_q  <= 1'b0;
    end else begin
      cells_q   <= cells_d;
      rd_data_q <= rd_data_d;
      wr_ack_q  <= wr_ack_d;
      wr_err_q  <= wr_err_d;
    end
  end

  assign wr_ack  = wr_ack_q;
  assign wr_err  = wr_err_q;
  assign rd_data = rd_data_q;

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      assign matrix_flat[(r*COLS+c)*WIDTH +: WIDTH] = cells_q[r][c];
    end
  end

`ifdef MATRIZ_TABLERO_OCC_EN
  logic [OCC_W-1:0] occ_q, occ_d, row_nz;
  logic [WIDTH-1:0] wr_old;

  // The counter tracks zero/non-zero transitions rather than recounting the board.
  always_comb begin
    wr_old = '0;
    row_nz = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (wr_row == 5'(r) && wr_col == 5'(c)) wr_old = cells_q[r][c];
        if (row_q == 5'(r) && cells_q[r][c] != '0) row_nz = row_nz + OCC_W'(1);
      end
    end
    occ_d = occ_q;
    if (state_q == CLEAR)     occ_d = occ_q - row_nz;
    else if (state_q == DONE) occ_d = '0;
    else if (wr_ack_d) begin
      if (wr_old == '0 && wr_data != '0)      occ_d = occ_q + OCC_W'(1);
      else if (wr_old != '0 && wr_data == '0) occ_d = occ_q - OCC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) occ_q <= '0;
    else        occ_q <= occ_d;
  end

  assign occ_count = occ_q;
`else
  assign occ_count = '0;
`endif

endmodule

// File: tb/tb_matriz_tablero.sv
// Self-checking bench for matriz_tablero: reference board model plus queues of expected ack/err and read data.
module tb_matriz_tablero;
  localparam int ROWS = 8, COLS = 8, WIDTH = 9;
  localparam int OCC_W = $clog2(ROWS*COLS+1);

  logic clk = 1'b0;
  logic reset, clr_req, wr_en;
  logic [4:0] wr_row, wr_col, rd_row, rd_col;
  logic [WIDTH-1:0] wr_data, rd_data;
  logic wr_ack, wr_err, busy, clr_done;
  logic [OCC_W-1:0] occ_count;
  logic [ROWS*COLS*WIDTH-1:0] matrix_flat;

  logic [WIDTH-1:0] model [ROWS][COLS];
  logic [1:0]       ackq [$];
  logic [WIDTH-1:0] rdq [$];
  logic [1:0]       ea;
  logic [WIDTH-1:0] er;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  matriz_tablero #(.ROWS(ROWS), .COLS(COLS), .WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .clr_req(clr_req), .wr_en(wr_en),
    .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data),
    .wr_ack(wr_ack), .wr_err(wr_err), .rd_row(rd_row), .rd_col(rd_col),
    .rd_data(rd_data), .busy(busy), .clr_done(clr_done),
    .occ_count(occ_count), .matrix_flat(matrix_flat)
  );

  function automatic logic [ROWS*COLS*WIDTH-1:0] flat_model();
    logic [ROWS*COLS*WIDTH-1:0] f;
    f = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        f[(r*COLS+c)*WIDTH +: WIDTH] = model[r][c];
    return f;
  endfunction

  function automatic int occ_model();
    int n;
    n = 0;
`ifdef MATRIZ_TABLERO_OCC_EN
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (model[r][c] != '0) n++;
`endif
    return n;
  endfunction

  function automatic void model_clear_row(int r);
    for (int c = 0; c < COLS; c++) model[r][c] = '0;
  endfunction

  // One clock of stimulus; expected ack/err and read data are queued before the edge.
  task automatic cycle_drive(input bit we, input int wr_r, input int wr_c, input logic [WIDTH-1:0] d,
                             input int rr, input int rc, input bit clr, input bit idle);
    bit acc;
    wr_en = we; wr_row = 5'(wr_r); wr_col = 5'(wr_c); wr_data = d;
    rd_row = 5'(rr); rd_col = 5'(rc); clr_req = clr;
    acc = we && idle && !clr;
    if (rr < ROWS && rc < COLS) rdq.push_back(model[rr][rc]);
    else rdq.push_back('0);
    if (acc && wr_r < ROWS && wr_c < COLS) begin
      ackq.push_back(2'b10);
      model[wr_r][wr_c] = d;
    end else if (acc) ackq.push_back(2'b01);
    else ackq.push_back(2'b00);
    @(posedge clk); #1;
    wr_en = 1'b0; clr_req = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; clr_req = 1'b0; wr_en = 1'b1; wr_row = 5'd1; wr_col = 5'd1;
    wr_data = 9'h1FF; rd_row = 5'd1; rd_col = 5'd1;
    for (int r = 0; r < ROWS; r++) model_clear_row(r);
    repeat (3) @(posedge clk);
    #1;
    checks += 6;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    if (clr_done !== 1'b0) begin errors++; $display("FAIL reset_clr_done got %b want 0", clr_done); end
    if ({wr_ack, wr_err} !== 2'b00) begin errors++; $display("FAIL reset_ack_err got %b want 00", {wr_ack, wr_err}); end
    if (rd_data !== '0) begin errors++; $display("FAIL reset_rd_data got %h want 0", rd_data); end
    if (occ_count !== '0) begin errors++; $display("FAIL reset_occ got %0d want 0", occ_count); end
    if (matrix_flat !== '0) begin errors++; $display("FAIL reset_matrix got nonzero want 0"); end
    wr_en = 1'b0;
    reset = 1'b1;
  endtask

  task automatic test_occupancy();
    int tr[3], tc[3], td[3], occ_exp[3];
    tr = '{1, 1, 2}; tc = '{1, 1, 2}; td = '{5, 0, 7};
`ifdef MATRIZ_TABLERO_OCC_EN
    occ_exp = '{1, 0, 1};
`else
    occ_exp = '{0, 0, 0};
`endif
    for (int i = 0; i < 3; i++) begin
      cycle_drive(1'b1, tr[i], tc[i], 9'(td[i]), 1, 1, 1'b0, 1'b1);
      ea = ackq.pop_front(); er = rdq.pop_front(); checks += 3;
      if ({wr_ack, wr_err} !== ea) begin errors++; $display("FAIL occ_ack step %0d got %b want %b", i, {wr_ack, wr_err}, ea); end
      if (rd_data !== er) begin errors++; $display("FAIL occ_rd step %0d got %h want %h", i, rd_data, er); end
      if (occ_count !== OCC_W'(occ_exp[i])) begin errors++; $display("FAIL occ_count step %0d got %0d want %0d", i, occ_count, occ_exp[i]); end
    end
  endtask

  task automatic test_write_read();
    int rr[3], rc[3];
    rr = '{3, 3, 0}; rc = '{5, 5, 9};
    for (int i = 0; i < 3; i++) begin
      cycle_drive(i == 0, 3, 5, 9'h1A5, rr[i], rc[i], 1'b0, 1'b1);
      ea = ackq.pop_front(); er = rdq.pop_front(); checks += 2;
      if ({wr_ack, wr_err} !== ea) begin errors++; $display("FAIL wr_ack step %0d got %b want %b", i, {wr_ack, wr_err}, ea); end
      if (rd_data !== er) begin errors++; $display("FAIL rd_data step %0d got %h want %h", i, rd_data, er); end
    end
    checks += 2;
    if (matrix_flat[(3*COLS+5)*WIDTH +: WIDTH] !== 9'h1A5) begin
      errors++; $display("FAIL flat_slice_3_5 got %h want 1a5", matrix_flat[(3*COLS+5)*WIDTH +: WIDTH]);
    end
    if (matrix_flat !== flat_model()) begin errors++; $display("FAIL flat_after_write got %h want %h", matrix_flat, flat_model()); end
  endtask

  task automatic test_out_of_range();
    int wr_r[2], wr_c[2];
    wr_r = '{8, 0}; wr_c = '{0, 8};
    for (int i = 0; i < 2; i++) begin
      cycle_drive(1'b1, wr_r[i], wr_c[i], 9'h001, 3, 5, 1'b0, 1'b1);
      ea = ackq.pop_front(); er = rdq.pop_front(); checks += 2;
      if ({wr_ack, wr_err} !== ea) begin errors++; $display("FAIL oor_ack_err step %0d got %b want %b", i, {wr_ack, wr_err}, ea); end
      if (rd_data !== er) begin errors++; $display("FAIL oor_rd step %0d got %h want %h", i, rd_data, er); end
    end
    checks++;
    if (matrix_flat !== flat_model()) begin errors++; $display("FAIL oor_unchanged got %h want %h", matrix_flat, flat_model()); end
  endtask

  task automatic test_clear();
    int busy_cycles;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        cycle_drive(1'b1, r, c, 9'h0FF, 7, 7, 1'b0, 1'b1);
        ea = ackq.pop_front(); er = rdq.pop_front(); checks += 2;
        if ({wr_ack, wr_err} !== ea) begin errors++; $display("FAIL fill_ack %0d,%0d got %b want %b", r, c, {wr_ack, wr_err}, ea); end
        if (rd_data !== er) begin errors++; $display("FAIL fill_rd %0d,%0d got %h want %h", r, c, rd_data, er); end
      end
    checks++;
    if (occ_count !== OCC_W'(occ_model())) begin errors++; $display("FAIL fill_occ got %0d want %0d", occ_count, occ_model()); end
    busy_cycles = 0;
    for (int k = 0; k <= ROWS + 1; k++) begin
      cycle_drive(1'b0, 0, 0, '0, 7, 7, k == 0, k == 0);
      ea = ackq.pop_front(); er = rdq.pop_front();
      if (k >= 1 && k <= ROWS) model_clear_row(k - 1);
      if (busy === 1'b1) busy_cycles++;
      checks += 5;
      if ({wr_ack, wr_err} !== ea) begin errors++; $display("FAIL clr_ack step %0d got %b want %b", k, {wr_ack, wr_err}, ea); end
      if (rd_data !== er) begin errors++; $display("FAIL clr_rd step %0d got %h want %h", k, rd_data, er); end
      if (clr_done !== (k == ROWS)) begin errors++; $display("FAIL clr_done step %0d got %b want %b", k, clr_done, k == ROWS); end
      if (matrix_flat !== flat_model()) begin errors++; $display("FAIL clr_flat step %0d got %h want %h", k, matrix_flat, flat_model()); end
      if (occ_count !== OCC_W'(occ_model())) begin errors++; $display("FAIL clr_occ step %0d got %0d want %0d", k, occ_count, occ_model()); end
    end
    checks++;
    if (busy_cycles != ROWS + 1) begin errors++; $display("FAIL clr_busy_cycles got %0d want %0d", busy_cycles, ROWS + 1); end
  endtask

  task automatic test_simultaneous();
    cycle_drive(1'b1, 0, 0, 9'h011, 0, 0, 1'b0, 1'b1);
    void'(ackq.pop_front()); void'(rdq.pop_front());
    cycle_drive(1'b1, 5, 5, 9'h022, 0, 0, 1'b0, 1'b1);
    void'(ackq.pop_front()); void'(rdq.pop_front());
    for (int k = 0; k <= ROWS + 1; k++) begin
      // k==0: clear and write together; k==3: repeated clr_req; k==ROWS+1: write during DONE
      cycle_drive(k == 0 || k == ROWS + 1, k == 0 ? 0 : 7, k == 0 ? 0 : 7,
                  k == 0 ? 9'h003 : 9'h055, 0, 0, k == 0 || k == 3, 1'b0);
      ea = ackq.pop_front(); er = rdq.pop_front();
      if (k >= 1 && k <= ROWS) model_clear_row(k - 1);
      checks += 4;
      if ({wr_ack, wr_err} !== ea) begin errors++; $display("FAIL sim_ack step %0d got %b want %b", k, {wr_ack, wr_err}, ea); end
      if (rd_data !== er) begin errors++; $display("FAIL sim_rd step %0d got %h want %h", k, rd_data, er); end
      if (busy !== (k <= ROWS)) begin errors++; $display("FAIL sim_busy step %0d got %b want %b", k, busy, k <= ROWS); end
      if (clr_done !== (k == ROWS)) begin errors++; $display("FAIL sim_clr_done step %0d got %b want %b", k, clr_done, k == ROWS); end
    end
    checks += 2;
    if (matrix_flat !== '0) begin errors++; $display("FAIL sim_flat got %h want 0", matrix_flat); end
    if (occ_count !== '0) begin errors++; $display("FAIL sim_occ got %0d want 0", occ_count); end
  endtask

  task automatic test_reset_mid_clear();
    cycle_drive(1'b1, 4, 4, 9'h0AA, 4, 4, 1'b0, 1'b1);
    void'(ackq.pop_front()); void'(rdq.pop_front());
    for (int k = 0; k <= 4; k++) begin
      cycle_drive(1'b0, 0, 0, '0, 4, 4, k == 0, k == 0);
      void'(ackq.pop_front()); void'(rdq.pop_front());
    end
    reset = 1'b0;
    #1;
    for (int r = 0; r < ROWS; r++) model_clear_row(r);
    checks += 6;
    if (busy !== 1'b0) begin errors++; $display("FAIL rmc_busy got %b want 0", busy); end
    if (clr_done !== 1'b0) begin errors++; $display("FAIL rmc_clr_done got %b want 0", clr_done); end
    if ({wr_ack, wr_err} !== 2'b00) begin errors++; $display("FAIL rmc_ack_err got %b want 00", {wr_ack, wr_err}); end
    if (rd_data !== '0) begin errors++; $display("FAIL rmc_rd got %h want 0", rd_data); end
    if (occ_count !== '0) begin errors++; $display("FAIL rmc_occ got %0d want 0", occ_count); end
    if (matrix_flat !== '0) begin errors++; $display("FAIL rmc_flat got %h want 0", matrix_flat); end
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      checks += 2;
      if (clr_done !== 1'b0) begin errors++; $display("FAIL rmc_hold_clr_done got %b want 0", clr_done); end
      if (busy !== 1'b0) begin errors++; $display("FAIL rmc_hold_busy got %b want 0", busy); end
    end
    reset = 1'b1;
    cycle_drive(1'b1, 2, 3, 9'h123, 2, 3, 1'b0, 1'b1);
    ea = ackq.pop_front(); er = rdq.pop_front(); checks += 3;
    if ({wr_ack, wr_err} !== ea) begin errors++; $display("FAIL rmc_first_ack got %b want %b", {wr_ack, wr_err}, ea); end
    if (rd_data !== er) begin errors++; $display("FAIL rmc_first_rd got %h want %h", rd_data, er); end
    if (matrix_flat !== flat_model()) begin errors++; $display("FAIL rmc_first_flat got %h want %h", matrix_flat, flat_model()); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 40; i++) begin
      cycle_drive($urandom_range(0, 3) != 0, $urandom_range(0, 9), $urandom_range(0, 9),
                  ($urandom_range(0, 3) == 0) ? 9'h000 : 9'($urandom),
                  $urandom_range(0, 9), $urandom_range(0, 9), 1'b0, 1'b1);
      ea = ackq.pop_front(); er = rdq.pop_front(); checks += 2;
      if ({wr_ack, wr_err} !== ea) begin errors++; $display("FAIL b2b_ack step %0d got %b want %b", i, {wr_ack, wr_err}, ea); end
      if (rd_data !== er) begin errors++; $display("FAIL b2b_rd step %0d got %h want %h", i, rd_data, er); end
    end
    checks += 2;
    if (matrix_flat !== flat_model()) begin errors++; $display("FAIL b2b_flat got %h want %h", matrix_flat, flat_model()); end
    if (occ_count !== OCC_W'(occ_model())) begin errors++; $display("FAIL b2b_occ got %0d want %0d", occ_count, occ_model()); end
  endtask

  initial begin
    test_reset();
    test_occupancy();
    test_write_read();
    test_out_of_range();
    test_clear();
    test_simultaneous();
    test_reset_mid_clear();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
